data_mem_ctrl: RTL and testbench

- Single-port-per-direction data memory that sits directly downstream of the core's load/store interface.
- Consumes the core's read request (mem_rd_req/addr) and write request (mem_wd_req/addr/data/sel).
- Returns load data with a fixed one-cycle latency, which the execute stage samples in the cycle after decode issues the read.
- Adds byte-lane writes, same-word read/write collision handling, out-of-range detection and access counters.

---
 rtl/data_mem_ctrl.sv | 95 +++++++++
 tb/tb_data_mem_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Data memory behind the core's load/store port: registered one-cycle reads, byte-lane writes,
// sticky out-of-range capture and saturating access counters. Define DMEM_FWD_EN for write-first collisions.
module data_mem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_req_i,
  input  logic [31:0]      rd_addr_i,
  output logic [31:0]      rd_data_o,
  input  logic             wd_req_i,
  input  logic [31:0]      wd_addr_i,
  input  logic [31:0]      wd_data_i,
  input  logic [3:0]       wd_sel_i,
  output logic             err_o,
  output logic [31:0]      err_addr_o,
  output logic [CNT_W-1:0] rd_cnt_o,
  output logic [CNT_W-1:0] wr_cnt_o
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   rd_off, wr_off;
  logic [AW-1:0] rd_idx, wr_idx;
  logic          rd_in, wr_in;
  logic          rd_ok, wr_ok, rd_oor, wr_oor;
  logic [31:0]   rd_word;

  always_comb begin
    rd_off = rd_addr_i - BASE_ADDR;
    wr_off = wd_addr_i - BASE_ADDR;
    rd_in  = rd_off < SPAN;
    wr_in  = wr_off < SPAN;
    rd_idx = rd_off[AW+1:2];
    wr_idx = wr_off[AW+1:2];
    rd_ok  = !rst && rd_req_i && rd_in;
    wr_ok  = !rst && wd_req_i && (wd_sel_i != 4'b0000) && wr_in;
    rd_oor = !rst && rd_req_i && !rd_in;
    wr_oor = !rst && wd_req_i && (wd_sel_i != 4'b0000) && !wr_in;
  end

  // Read word seen at the edge; with forwarding, same-cycle store lanes override the array.
  always_comb begin
    rd_word = mem[rd_idx];
`ifdef DMEM_FWD_EN
    if (wr_ok && (wr_idx == rd_idx)) begin
      for (int unsigned n = 0; n < 4; n++) begin
        if (wd_sel_i[n]) rd_word[8*n +: 8] = wd_data_i[8*n +: 8];
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int unsigned n = 0; n < 4; n++) begin
        if (wd_sel_i[n]) mem[wr_idx][8*n +: 8] <= wd_data_i[8*n +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_o <= '0;
    end else if (rd_req_i) begin
      rd_data_o <= rd_in ? rd_word : '0;
    end
  end

  // First error wins; a simultaneous bad store takes priority over the bad load.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_o      <= 1'b0;
      err_addr_o <= '0;
    end else if (rd_oor || wr_oor) begin
      err_o <= 1'b1;
      if (!err_o) err_addr_o <= wr_oor ? wd_addr_i : rd_addr_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_o <= '0;
      wr_cnt_o <= '0;
    end else begin
      if (rd_ok && (rd_cnt_o != '1)) rd_cnt_o <= rd_cnt_o + 1'b1;
      if (wr_ok && (wr_cnt_o != '1)) wr_cnt_o <= wr_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl (16 words, 4-bit counters); honours DMEM_FWD_EN for the collision vector.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_req_i = 1'b0;
  logic [31:0] rd_addr_i = '0;
  logic [31:0] rd_data_o;
  logic        wd_req_i = 1'b0;
  logic [31:0] wd_addr_i = '0;
  logic [31:0] wd_data_i = '0;
  logic [3:0]  wd_sel_i = '0;
  logic        err_o;
  logic [31:0] err_addr_o;
  logic [3:0]  rd_cnt_o;
  logic [3:0]  wr_cnt_o;

  data_mem_ctrl #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
    .wd_req_i(wd_req_i), .wd_addr_i(wd_addr_i), .wd_data_i(wd_data_i), .wd_sel_i(wd_sel_i),
    .err_o(err_o), .err_addr_o(err_addr_o), .rd_cnt_o(rd_cnt_o), .wr_cnt_o(wr_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned what;   // 0 rd_data, 1 err, 2 err_addr, 3 rd_cnt, 4 wr_cnt
    logic [31:0] exp;
  } stat_t;

  logic [31:0] exp_q[$];
  stat_t       stat_q[$];
  logic        pend = 1'b0;
  logic        done = 1'b0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always @(posedge clk) pend <= rd_req_i;

  // Monitor: owns every comparison and the summary.
  always @(negedge clk) begin
    logic [31:0] e, a;
    string nm;
    if (pend) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_data_unexpected: got %08h, required no load response", rd_data_o);
      end else begin
        e = exp_q.pop_front();
        if (rd_data_o !== e) begin
          n_err++;
          $display("FAIL rd_data: got %08h, required %08h", rd_data_o, e);
        end
      end
    end
    while (stat_q.size() > 0) begin
      stat_t s;
      s = stat_q.pop_front();
      case (s.what)
        0: begin nm = "rd_data_hold"; a = rd_data_o; end
        1: begin nm = "err"; a = {31'b0, err_o}; end
        2: begin nm = "err_addr"; a = err_addr_o; end
        3: begin nm = "rd_cnt"; a = {28'b0, rd_cnt_o}; end
        default: begin nm = "wr_cnt"; a = {28'b0, wr_cnt_o}; end
      endcase
      n_cmp++;
      if (a !== s.exp) begin
        n_err++;
        $display("FAIL %s: got %08h, required %08h", nm, a, s.exp);
      end
    end
    if (done) begin
      n_cmp++;
      if (exp_q.size() != 0) begin
        n_err++;
        $display("FAIL rd_data_missing: got %0d responses outstanding, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required run completion");
    $fatal(1, "timeout");
  end

  task automatic stat(input int unsigned what, input logic [31:0] exp);
    stat_t s;
    s.what = what;
    s.exp  = exp;
    stat_q.push_back(s);
    @(posedge clk); #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    rd_req_i = 1'b0;
    wd_req_i = 1'b0;
    rst      = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wd_req_i = 1'b1; wd_addr_i = a; wd_data_i = d; wd_sel_i = s;
    tick();
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp);
    rd_req_i = 1'b1; rd_addr_i = a;
    exp_q.push_back(exp);
    tick();
  endtask

  task automatic both(input logic [31:0] ra, input logic [31:0] exp,
                      input logic [31:0] wa, input logic [31:0] d, input logic [3:0] s);
    rd_req_i = 1'b1; rd_addr_i = ra;
    wd_req_i = 1'b1; wd_addr_i = wa; wd_data_i = d; wd_sel_i = s;
    exp_q.push_back(exp);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
  endtask

  logic [31:0] loop_addr [5] = '{32'h10, 32'h20, 32'h30, 32'h34, 32'h04};
  logic [31:0] loop_data [5] = '{32'hDEADBEEF, 32'h11BB33DD, 32'h0000FFFF, 32'h12345678, 32'hCAFEF00D};

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    stat(0, 32'h0); stat(1, 32'h0); stat(2, 32'h0); stat(3, 32'h0); stat(4, 32'h0);

    wr(32'h10, 32'hDEADBEEF, 4'hF);
    rd(32'h10, 32'hDEADBEEF);
    stat(4, 32'd1); stat(3, 32'd1);

    wr(32'h20, 32'h11223344, 4'hF);
    wr(32'h20, 32'hAABBCCDD, 4'b0101);
    rd(32'h20, 32'h11BB33DD);

    wr(32'h30, 32'h00000000, 4'hF);
`ifdef DMEM_FWD_EN
    both(32'h30, 32'h0000FFFF, 32'h30, 32'hFFFFFFFF, 4'b0011);
`else
    both(32'h30, 32'h00000000, 32'h30, 32'hFFFFFFFF, 4'b0011);
`endif
    rd(32'h30, 32'h0000FFFF);

    both(32'h10, 32'hDEADBEEF, 32'h34, 32'h12345678, 4'hF);
    rd(32'h34, 32'h12345678);
    wr(32'h10, 32'h00000000, 4'b0000);
    rd(32'h10, 32'hDEADBEEF);
    tick(); tick();
    stat(0, 32'hDEADBEEF);
    wr(32'h04, 32'hCAFEF00D, 4'hF);
    stat(4, 32'd7); stat(3, 32'd7);

    rd(32'h40, 32'h0);
    wr(32'h44, 32'hFFFFFFFF, 4'hF);
    stat(1, 32'h1); stat(2, 32'h40); stat(4, 32'd7); stat(3, 32'd7);
    rd(32'h04, 32'hCAFEF00D);
    stat(3, 32'd8);
    do_reset();
    stat(1, 32'h0); stat(2, 32'h0); stat(3, 32'h0); stat(4, 32'h0); stat(0, 32'h0);

    both(32'h80, 32'h0, 32'h100, 32'h0, 4'b0001);
    stat(1, 32'h1); stat(2, 32'h100);
    rd(32'h48, 32'h0);
    stat(1, 32'h1); stat(2, 32'h100); stat(3, 32'h0); stat(4, 32'h0);
    do_reset();

    for (int i = 0; i < 20; i++) rd(loop_addr[i % 5], loop_data[i % 5]);
    stat(3, 32'hF); stat(4, 32'h0);

    rst = 1'b1;
    rd(32'h10, 32'h0);
    stat(3, 32'h0); stat(1, 32'h0);

    tick(); tick();
    done = 1'b1;
  end

endmodule
